// File: rtl/button_event_filter.sv
// -----------------------------------------------------------------------------
// button_event_filter
//
// Debounces a raw push-button level and turns it into a set of registered
// events: press, release, long-press and (optionally) auto-repeat.
//
// Build option:
//   BTN_AUTOREPEAT_EN  defined   -> HELD issues repeat_pulse every REPEAT_CYCLES
//                      undefined -> no repeat counter, repeat_pulse tied to 0
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a press/release
//   LONG_CYCLES      cycles of debounced press before long_pulse
//   REPEAT_CYCLES    auto-repeat period while held
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   btn_in         raw asynchronous button level (1 = pressed)
//   pressed        debounced level
//   press_pulse    one-cycle strobe on accepted press
//   release_pulse  one-cycle strobe on accepted release
//   long_pulse     one-cycle strobe when the press reaches LONG_CYCLES
//   repeat_pulse   one-cycle auto-repeat strobe
//
// FSM states:
//   state      | meaning
//   IDLE       | button released and stable
//   DB_PRESS   | sync high, counting stable samples towards a press
//   PRESSED    | press accepted, hold counter running towards long-press
//   HELD       | long-press issued, auto-repeat running (if built)
//   DB_RELEASE | sync low, counting stable samples towards a release;
//              | hold/repeat counters frozen, returns to origin on bounce
// -----------------------------------------------------------------------------
module button_event_filter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        HELD       = 3'd3,
        DB_RELEASE = 3'd4
    } state_t;

    logic              sync_meta;
    logic              sync;
    state_t            state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              from_held, from_held_nxt;

    // Transition events and their one-stage delay. The extra stage lines the
    // strobes up with the `pressed` level, which is registered from state.
    logic press_ev, release_ev, long_ev;
    logic press_ev_q, release_ev_q, long_ev_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             repeat_ev, repeat_ev_q;
`endif

    // Two-flop synchronizer; only `sync` is seen by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            from_held <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            from_held <= from_held_nxt;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt   <= rep_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        hold_cnt_nxt  = hold_cnt;
        from_held_nxt = from_held;
        press_ev      = 1'b0;
        release_ev    = 1'b0;
        long_ev       = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rep_cnt_nxt   = rep_cnt;
        repeat_ev     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt  = DB_PRESS;
                    db_cnt_nxt = '0;
                end
            end
            DB_PRESS: begin
                if (!sync) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt    = PRESSED;
                    press_ev     = 1'b1;
                    hold_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_nxt     = DB_RELEASE;
                    db_cnt_nxt    = '0;
                    from_held_nxt = 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = HELD;
                    long_ev   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    rep_cnt_nxt = '0;
`endif
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_nxt     = DB_RELEASE;
                    db_cnt_nxt    = '0;
                    from_held_nxt = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (rep_cnt == REP_LAST) begin
                    repeat_ev   = 1'b1;
                    rep_cnt_nxt = '0;
                end else begin
                    rep_cnt_nxt = rep_cnt + REP_W'(1);
                end
`endif
            end
            DB_RELEASE: begin
                // A bounce back high resumes the origin with counters intact.
                if (sync) begin
                    state_nxt = from_held ? HELD : PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = IDLE;
                    release_ev = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_ev_q    <= 1'b0;
            release_ev_q  <= 1'b0;
            long_ev_q     <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_ev_q    <= press_ev;
            release_ev_q  <= release_ev;
            long_ev_q     <= long_ev;
            pressed       <= (state == PRESSED) || (state == HELD) ||
                             (state == DB_RELEASE);
            press_pulse   <= press_ev_q;
            release_pulse <= release_ev_q;
            long_pulse    <= long_ev_q;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_ev_q  <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_ev_q  <= repeat_ev;
            repeat_pulse <= repeat_ev_q;
        end
    end
`else
    // Without autorepeat the period has no meaning; both arms are 0, the
    // reference only keeps the parameter list identical across builds.
    assign repeat_pulse = (REPEAT_CYCLES < 1) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_button_event_filter.sv
// -----------------------------------------------------------------------------
// tb_button_event_filter
//
// Directed bench for button_event_filter with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=20, REPEAT_CYCLES=5. Repeat expectations follow the
// BTN_AUTOREPEAT_EN build option. Cycle indices count from the first rising
// edge that samples btn_in=1 (index 0); outputs are sampled 1 time unit after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_button_event_filter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

    int total = 0;
    int bad = 0;

    button_event_filter #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .REPEAT_CYCLES  (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int hi;         // btn_in high for sample indices [0, hi)
        int g0;         // low gap [g0, g1) inside the high window
        int g1;
        int exp_press;  // -1 = none
        int exp_long;
        int exp_rel;
        int exp_rep_n;  // repeat count when autorepeat is built
        int exp_rep_first;
    } vec_t;

    // observations of the last run
    int o_press_at, o_long_at, o_rel_at, o_rep_first;
    int o_n_press, o_n_long, o_n_rel, o_n_rep;
    int o_rise, o_fall, o_multi;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic btn_at(input int c, input int hi, input int g0, input int g1);
        return (c < hi) && !(c >= g0 && c < g1);
    endfunction

    task automatic clear_obs();
        o_press_at = -1; o_long_at = -1; o_rel_at = -1; o_rep_first = -1;
        o_n_press = 0; o_n_long = 0; o_n_rel = 0; o_n_rep = 0;
        o_rise = -1; o_fall = -1; o_multi = 0;
    endtask

    task automatic observe(input int cyc);
        int n;
        n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
        if (n > 1) o_multi++;
        if (press_pulse) begin
            o_n_press++;
            if (o_press_at < 0) o_press_at = cyc;
        end
        if (long_pulse) begin
            o_n_long++;
            if (o_long_at < 0) o_long_at = cyc;
        end
        if (release_pulse) begin
            o_n_rel++;
            if (o_rel_at < 0) o_rel_at = cyc;
        end
        if (repeat_pulse) begin
            o_n_rep++;
            if (o_rep_first < 0) o_rep_first = cyc;
        end
        if (pressed && o_rise < 0) o_rise = cyc;
        if (!pressed && o_rise >= 0 && o_fall < 0) o_fall = cyc;
    endtask

    task automatic run_vec(input int hi, input int g0, input int g1, input int ncyc);
        clear_obs();
        @(negedge clk);
        btn_in = btn_at(0, hi, g0, g1);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            observe(c);
            btn_in = btn_at(c + 1, hi, g0, g1);
        end
        btn_in = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        int   exp_rep_n, exp_rep_first;
        string tag;

        vecs[0] = '{3,  0,  0,  -1, -1, -1, 0, -1};  // short glitch
        vecs[1] = '{4,  0,  0,  -1, -1, -1, 0, -1};  // one sample short
        vecs[2] = '{5,  0,  0,   7, -1, 12, 0, -1};  // minimum accepted press
        vecs[3] = '{12, 2,  3,  10, -1, 19, 0, -1};  // bounce during debounce
        vecs[4] = '{24, 0,  0,   7, -1, 31, 0, -1};  // released just before long
        vecs[5] = '{25, 0,  0,   7, 27, 32, 0, -1};  // just reaches long
        vecs[6] = '{40, 0,  0,   7, 27, 47, 3, 32};  // long + repeats
        vecs[7] = '{40, 10, 12,  7, 30, 47, 2, 35};  // bounce in PRESSED freezes hold
        vecs[8] = '{60, 0,  0,   7, 27, 67, 7, 32};  // long hold

        // reset state
        #12;
        check("reset_outputs",
              int'({pressed, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
`ifdef BTN_AUTOREPEAT_EN
            exp_rep_n     = v.exp_rep_n;
            exp_rep_first = v.exp_rep_first;
`else
            exp_rep_n     = 0;
            exp_rep_first = -1;
`endif
            run_vec(v.hi, v.g0, v.g1, v.hi + 12);
            tag = $sformatf("v%0d_", i);
            check({tag, "press_at"},   o_press_at, v.exp_press);
            check({tag, "n_press"},    o_n_press,  (v.exp_press >= 0) ? 1 : 0);
            check({tag, "long_at"},    o_long_at,  v.exp_long);
            check({tag, "n_long"},     o_n_long,   (v.exp_long >= 0) ? 1 : 0);
            check({tag, "rel_at"},     o_rel_at,   v.exp_rel);
            check({tag, "n_rel"},      o_n_rel,    (v.exp_rel >= 0) ? 1 : 0);
            check({tag, "n_rep"},      o_n_rep,    exp_rep_n);
            check({tag, "rep_first"},  o_rep_first, exp_rep_first);
            check({tag, "pressed_rise"}, o_rise,   v.exp_press);
            check({tag, "pressed_fall"}, o_fall,   v.exp_rel);
            check({tag, "multi_pulse"},  o_multi,  0);
            repeat (3) @(negedge clk);
        end

        // Reset while HELD with the button kept high.
        clear_obs();
        @(negedge clk);
        btn_in = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            observe(c);
        end
        check("rst_pre_long_at", o_long_at, 27);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              int'({pressed, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            observe(100 + c);
        end
        check("rst_hold_outputs",
              int'({pressed, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        check("rst_no_release_before", o_n_rel, 0);
        clear_obs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            observe(c);
        end
        check("rst_repress_at", o_press_at, 7);
        check("rst_repress_n", o_n_press, 1);
        check("rst_pressed_rise", o_rise, 7);
        check("rst_no_release_after", o_n_rel, 0);

        // release after the re-press
        clear_obs();
        @(negedge clk);
        btn_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            observe(c);
        end
        check("rst_release_at", o_rel_at, 7);
        check("rst_release_pressed", int'(pressed), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
